// File: rtl/alarm_time_keeper.sv
// alarm_time_keeper
//   Timebase and time/alarm register block for the alarm clock display driver.
//   Divides clk down to seconds, keeps 24-hour BCD HH:MM time, and lets the
//   user set the time or the alarm using the hour/minute buttons.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   set_time      level, time-set mode (halts running time)
//   set_alarm     level, alarm-set mode (ignored while set_time is high)
//   inc_hr        button, +1 hour to the selected register on its rising edge
//   inc_min       button, +1 minute to the selected register on its rising edge
//   current_time  BCD {H10,H1,M10,M1}
//   alarm_time    BCD {H10,H1,M10,M1}
//   one_minute    one-cycle pulse, the cycle after current_time rolls a minute
//   sec_tick      one-cycle pulse per elapsed second
module alarm_time_keeper #(
    parameter int unsigned CLKS_PER_SEC = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_time,
    input  logic        set_alarm,
    input  logic        inc_hr,
    input  logic        inc_min,
    output logic [15:0] current_time,
    output logic [15:0] alarm_time,
    output logic        one_minute,
    output logic        sec_tick
);

    localparam int unsigned PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_SEC - 1);

    logic [PW-1:0] prescaler;
    logic [5:0]    seconds;
    logic          inc_hr_q;
    logic          inc_min_q;
    logic          roll_pend;

    logic hr_rise;
    logic min_rise;
    logic pre_wrap;
    logic min_roll;

    // BCD minutes +1, 59 -> 00 (no carry out)
    function automatic logic [7:0] next_min(input logic [7:0] m);
        if (m[3:0] == 4'd9)
            return (m[7:4] == 4'd5) ? 8'h00 : {m[7:4] + 4'd1, 4'd0};
        else
            return {m[7:4], m[3:0] + 4'd1};
    endfunction

    // BCD hours +1, 23 -> 00
    function automatic logic [7:0] next_hr(input logic [7:0] h);
        if (h == 8'h23)
            return 8'h00;
        else if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        else
            return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // Button edit: independent hour and minute steps, minutes never carry
    function automatic logic [15:0] edit(input logic [15:0] t, input logic hr, input logic mn);
        return {hr ? next_hr(t[15:8]) : t[15:8], mn ? next_min(t[7:0]) : t[7:0]};
    endfunction

    always_comb begin
        hr_rise  = inc_hr & ~inc_hr_q;
        min_rise = inc_min & ~inc_min_q;
        pre_wrap = (prescaler == PRE_LAST);
        min_roll = pre_wrap && (seconds == 6'd59);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            seconds      <= '0;
            inc_hr_q     <= 1'b0;
            inc_min_q    <= 1'b0;
            roll_pend    <= 1'b0;
            current_time <= '0;
            alarm_time   <= '0;
            one_minute   <= 1'b0;
            sec_tick     <= 1'b0;
        end else begin
            inc_hr_q  <= inc_hr;
            inc_min_q <= inc_min;
            if (set_time) begin
                prescaler    <= '0;
                seconds      <= '0;
                sec_tick     <= 1'b0;
                one_minute   <= 1'b0;
                roll_pend    <= 1'b0;
                current_time <= edit(current_time, hr_rise, min_rise);
            end else begin
                prescaler <= pre_wrap ? '0 : prescaler + 1'b1;
                sec_tick  <= pre_wrap;
                if (pre_wrap)
                    seconds <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
                // one_minute trails the time update by one cycle via roll_pend
                roll_pend  <= min_roll;
                one_minute <= roll_pend;
                if (min_roll)
                    current_time <= {(current_time[7:0] == 8'h59) ? next_hr(current_time[15:8])
                                                                  : current_time[15:8],
                                     next_min(current_time[7:0])};
                if (set_alarm)
                    alarm_time <= edit(alarm_time, hr_rise, min_rise);
            end
        end
    end

endmodule

// File: tb/tb_alarm_time_keeper.sv
module tb_alarm_time_keeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        set_time = 1'b0;
    logic        set_alarm = 1'b0;
    logic        inc_hr = 1'b0;
    logic        inc_min = 1'b0;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic        one_minute;
    logic        sec_tick;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned st_cnt = 0;
    int unsigned om_cnt = 0;

    alarm_time_keeper #(.CLKS_PER_SEC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_time     (set_time),
        .set_alarm    (set_alarm),
        .inc_hr       (inc_hr),
        .inc_min      (inc_min),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .one_minute   (one_minute),
        .sec_tick     (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sec_tick) st_cnt++;
        if (one_minute) om_cnt++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic press_hr(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            inc_hr = 1'b1; tick();
            inc_hr = 1'b0; tick();
        end
    endtask

    task automatic press_min(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            inc_min = 1'b1; tick();
            inc_min = 1'b0; tick();
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        st_cnt = 0;
        om_cnt = 0;
    endtask

    initial begin
        // Reset state, then one minute of free running
        do_reset();
        check("rst_time", current_time, 16'h0000);
        check("rst_alarm", alarm_time, 16'h0000);
        check("rst_om", one_minute, 1'b0);
        check("rst_st", sec_tick, 1'b0);
        run(239);
        check("t1_before", current_time, 16'h0000);
        run(1);
        check("t1_time", current_time, 16'h0001);
        check("t1_st_cnt", st_cnt, 60);
        check("t1_om_early", om_cnt, 0);
        tick();
        check("t1_om_pulse", one_minute, 1'b1);
        tick();
        check("t1_om_single", one_minute, 1'b0);

        // Set-time edits from 00:00, no carry from minutes, no strobes
        do_reset();
        set_time = 1'b1;
        press_hr(25);
        check("t4_hr_wrap", current_time, 16'h0100);
        press_min(60);
        check("t4_min_nocarry", current_time, 16'h0100);
        check("t4_no_st", st_cnt, 0);
        check("t4_no_om", om_cnt, 0);
        press_hr(22);
        press_min(59);
        check("t2_set", current_time, 16'h2359);

        // 23:59 -> 00:00
        set_time = 1'b0;
        st_cnt = 0; om_cnt = 0;
        run(240);
        check("t2_roll", current_time, 16'h0000);
        check("t2_st_cnt", st_cnt, 60);
        check("t2_om_early", om_cnt, 0);
        tick();
        check("t2_om_pulse", one_minute, 1'b1);

        // 09:59 -> 10:00
        set_time = 1'b1;
        press_hr(9);
        press_min(59);
        check("t3_set", current_time, 16'h0959);
        set_time = 1'b0;
        st_cnt = 0; om_cnt = 0;
        run(240);
        check("t3_roll", current_time, 16'h1000);
        tick();
        check("t3_om_pulse", one_minute, 1'b1);

        // Alarm edit while time keeps running (roll at 480 edges after release)
        set_alarm = 1'b1;
        st_cnt = 0; om_cnt = 0;
        press_hr(7);
        press_min(30);
        check("t5_alarm", alarm_time, 16'h0730);
        check("t5_time_held", current_time, 16'h1000);
        run(170);
        check("t5_time_run", current_time, 16'h1001);
        check("t5_om_cnt", om_cnt, 1);
        check("t5_st_cnt", st_cnt, 61);
        check("t5_alarm_keep", alarm_time, 16'h0730);

        // Both modes high: time edits, alarm untouched
        set_time = 1'b1;
        press_hr(1);
        press_min(1);
        check("t5_both_time", current_time, 16'h1102);
        check("t5_both_alarm", alarm_time, 16'h0730);

        // Neither mode: buttons ignored
        set_time = 1'b0;
        set_alarm = 1'b0;
        press_hr(1);
        press_min(1);
        check("idle_time", current_time, 16'h1102);
        check("idle_alarm", alarm_time, 16'h0730);

        // Reset mid-operation at 12:34 while sec_tick is high
        set_time = 1'b1;
        press_hr(1);
        press_min(32);
        check("t6_set", current_time, 16'h1234);
        set_time = 1'b0;
        run(4);
        check("t6_st_high", sec_tick, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_time", current_time, 16'h0000);
        check("t6_rst_alarm", alarm_time, 16'h0000);
        check("t6_rst_st", sec_tick, 1'b0);
        check("t6_rst_om", one_minute, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        st_cnt = 0; om_cnt = 0;
        run(239);
        check("t6_before", current_time, 16'h0000);
        run(1);
        check("t6_time", current_time, 16'h0001);
        check("t6_st_cnt", st_cnt, 60);
        tick();
        check("t6_om_pulse", one_minute, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
